// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the fetch/load-store bus arbiter: access sizes and FSM states.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_IF_ADDR  = 3'd1,
        ARB_IF_DATA  = 3'd2,
        ARB_MEM_ADDR = 3'd3,
        ARB_MEM_DATA = 3'd4
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates the single memory bus port between instruction fetch and load/store,
// with registered grants, one-cycle done pulses and stale-fetch draining on flush.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ARB_IDLE     | no transaction; pick an eligible requester (MEM first)
// ARB_IF_ADDR  | fetch request on the bus, waiting for bus_ready
// ARB_IF_DATA  | fetch accepted, waiting for bus_rvalid
// ARB_MEM_ADDR | load/store request on the bus, waiting for bus_ready
// ARB_MEM_DATA | load/store accepted, waiting for bus_rvalid (data or write ack)
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,

    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [1:0]          mem_size,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_done,

    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [1:0]          bus_size,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,

    output logic                if_stall_req,
    output logic                mem_stall_req
);

    arb_state_e state;
    logic       drop;
    logic       if_elig;
    logic       mem_elig;

    // A requester in its done cycle still shows the old address on its req lines.
    assign if_elig       = if_req & ~if_done;
    assign mem_elig      = mem_req & ~mem_done;

    assign if_stall_req  = if_req & ~if_done;
    assign mem_stall_req = mem_req & ~mem_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            drop      <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            bus_size  <= 2'b00;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (mem_elig) begin
                        bus_valid <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        bus_wstrb <= mem_wstrb;
                        bus_size  <= mem_size;
                        state     <= ARB_MEM_ADDR;
                    end else if (if_elig) begin
                        bus_valid <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= if_addr;
                        bus_wdata <= '0;
                        bus_wstrb <= '0;
                        bus_size  <= SIZE_D;
                        state     <= ARB_IF_ADDR;
                    end
                end
                ARB_IF_ADDR: begin
                    if (if_flush)
                        drop <= 1'b1;
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        state     <= ARB_IF_DATA;
                    end
                end
                ARB_IF_DATA: begin
                    if (bus_rvalid) begin
                        // A flush arriving with the data also makes it stale.
                        if (!(drop || if_flush)) begin
                            if_rdata <= bus_rdata;
                            if_done  <= 1'b1;
                        end
                        drop  <= 1'b0;
                        state <= ARB_IDLE;
                    end else if (if_flush) begin
                        drop <= 1'b1;
                    end
                end
                ARB_MEM_ADDR: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        state     <= ARB_MEM_DATA;
                    end
                end
                ARB_MEM_DATA: begin
                    if (bus_rvalid) begin
                        mem_rdata <= bus_rdata;
                        mem_done  <= 1'b1;
                        state     <= ARB_IDLE;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    bus_valid <= 1'b0;
                    drop      <= 1'b0;
                end
            endcase
        end
    end

endmodule
